// File: rtl/axi_m_pkg.sv
// axi_m_pkg: shared state encoding, AXI response codes and timeout constants for the AXI-Lite master bridge
package axi_m_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WRESP = 3'd2,
        RD_A  = 3'd3,
        RD_D  = 3'd4,
        DONE  = 3'd5
    } state_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/axi_m_watchdog.sv
// axi_m_watchdog: cycle counter that flags expiry on the LIMIT-th enabled cycle since the last clear
module axi_m_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(LIMIT);
    logic [W-1:0] cnt;
    assign expired = en && (cnt == W'(LIMIT - 1));
    // count enabled cycles; restart whenever the bridge is idle
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/axi_m_adapter.sv
// axi_m_adapter: native request to single-beat AXI4-Lite master bridge; watchdog enabled by AXI_M_TIMEOUT_EN
module axi_m_adapter
    import axi_m_pkg::*;
#(
    parameter int         ADDR_W         = 32,
    parameter logic [2:0] AXI_PROT       = 3'b000,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    output logic              bus_err,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awprot,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [1:0]        m_bresp,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp
);
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    state_t            state, next;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done, w_done, err_q, timeout;
    logic              aw_hs, w_hs;

    assign m_awvalid = (state == WR) && !aw_done;
    assign m_wvalid  = (state == WR) && !w_done;
    assign m_bready  = (state == WRESP);
    assign m_arvalid = (state == RD_A);
    assign m_rready  = (state == RD_D);
    assign mem_ready = (state == DONE);
    assign bus_err   = mem_ready && err_q;
    assign mem_rdata = rdata_q;
    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_awprot  = AXI_PROT;
    assign m_arprot  = AXI_PROT;
    assign aw_hs     = m_awvalid && m_awready;
    assign w_hs      = m_wvalid && m_wready;

`ifdef AXI_M_TIMEOUT_EN
    axi_m_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == IDLE),
        .en     (state inside {WR, WRESP, RD_A, RD_D}),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next;
    end

    // next-state: one transaction at a time, watchdog expiry forces completion
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (mem_valid) next = |mem_wstrb ? WR : RD_A;
            WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) next = WRESP;
            WRESP:   if (m_bvalid) next = WRESP == state ? DONE : state;
            RD_A:    if (m_arready) next = RD_D;
            RD_D:    if (m_rvalid) next = DONE;
            default: next = IDLE;
        endcase
        if (timeout) next = DONE;
    end

    // request capture, per-channel write progress, response latching
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (mem_valid) begin
                    addr_q  <= mem_addr;
                    wdata_q <= mem_wdata;
                    wstrb_q <= mem_wstrb;
                end
            end
            if (state == WR) begin
                aw_done <= aw_done || aw_hs;
                w_done  <= w_done || w_hs;
            end
            if (state == WRESP && m_bvalid) err_q <= m_bresp[1];
            if (state == RD_D && m_rvalid) begin
                rdata_q <= m_rdata;
                err_q   <= m_rresp[1];
            end
            if (timeout) begin
                rdata_q <= TIMEOUT_RDATA;
                err_q   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_m_adapter.sv
// tb_axi_m_adapter: directed and randomized checks of axi_m_adapter against a latency/response model; honours AXI_M_TIMEOUT_EN
module tb_axi_m_adapter;
    import axi_m_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_ready, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    int          aw_d, w_d, b_d, ar_d, r_d;
    bit          ar_never;
    logic [1:0]  bresp_v, rresp_v;
    logic [31:0] rdata_v;

    int          cyc = 0;
    int          aw_n = 0, w_n = 0, ar_n = 0, proto_n = 0;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit          aw_got, w_got, b_pend, r_pend;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic [2:0]  cap_awprot, cap_arprot;
    bit          aw_st, w_st, ar_st;
    logic [31:0] aw_pa, w_pd, ar_pa;
    logic [3:0]  w_ps;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    axi_m_adapter #(.ADDR_W(32), .AXI_PROT(3'b000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .bus_err(bus_err),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    // slave: each ready rises after its configured number of stalled cycles; responses follow with their own delays
    assign m_awready = m_awvalid && aw_cnt >= aw_d;
    assign m_wready  = m_wvalid && w_cnt >= w_d;
    assign m_arready = m_arvalid && !ar_never && ar_cnt >= ar_d;
    assign m_bvalid  = b_pend && b_cnt >= b_d;
    assign m_rvalid  = r_pend && r_cnt >= r_d;
    assign m_bresp   = bresp_v;
    assign m_rresp   = rresp_v;
    assign m_rdata   = rdata_v;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
            aw_st <= 0; w_st <= 0; ar_st <= 0;
        end else begin
            aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
            if (m_awvalid && m_awready) begin aw_n <= aw_n + 1; cap_awaddr <= m_awaddr; cap_awprot <= m_awprot; end
            if (m_wvalid && m_wready) begin w_n <= w_n + 1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb; end
            if (m_arvalid && m_arready) begin ar_n <= ar_n + 1; cap_araddr <= m_araddr; cap_arprot <= m_arprot; end
            if (b_pend) b_cnt <= b_cnt + 1;
            if (m_bvalid && m_bready) b_pend <= 0;
            if ((aw_got || (m_awvalid && m_awready)) && (w_got || (m_wvalid && m_wready))) begin
                aw_got <= 0; w_got <= 0; b_pend <= 1; b_cnt <= 0;
            end else begin
                aw_got <= aw_got || (m_awvalid && m_awready);
                w_got  <= w_got || (m_wvalid && m_wready);
            end
            if (r_pend) r_cnt <= r_cnt + 1;
            if (m_rvalid && m_rready) r_pend <= 0;
            if (m_arvalid && m_arready) begin r_pend <= 1; r_cnt <= 0; end
            if (aw_st && (!m_awvalid || m_awaddr !== aw_pa)) proto_n <= proto_n + 1;
            if (w_st && (!m_wvalid || m_wdata !== w_pd || m_wstrb !== w_ps)) proto_n <= proto_n + 1;
            if (ar_st && !ar_never && (!m_arvalid || m_araddr !== ar_pa)) proto_n <= proto_n + 1;
            aw_st <= m_awvalid && !m_awready; aw_pa <= m_awaddr;
            w_st  <= m_wvalid && !m_wready; w_pd <= m_wdata; w_ps <= m_wstrb;
            ar_st <= m_arvalid && !m_arready; ar_pa <= m_araddr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {25'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, mem_ready, bus_err}, 32'd0);
    endtask

    function automatic bit is_err(input logic [1:0] r);
        return r == RESP_SLVERR || r == RESP_DECERR;
    endfunction

    // one native transaction; the model predicts latency, response and the AXI payload seen by the slave
    task automatic run(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        int  aw0, w0, ar0, p0, st, lat, e_lat;
        bit  got, wr;
        wr = (s != 4'h0);
        aw0 = aw_n; w0 = w_n; ar0 = ar_n; p0 = proto_n;
        mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        st = cyc; got = 0;
        @(negedge clk);
        mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
        for (int i = 0; i < 200 && !got; i++) begin
            if (mem_ready) got = 1;
            else @(negedge clk);
        end
        lat = cyc - st + 1;
        e_lat = wr ? (aw_d > w_d ? aw_d : w_d) + b_d + 4 : ar_d + r_d + 4;
        if (!wr) exp_rdata = rdata_v;
        chk({tag, "_ready"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'(is_err(wr ? bresp_v : rresp_v)));
        chk({tag, "_rdata"}, mem_rdata, exp_rdata);
        mem_valid = 0;
        @(negedge clk);
        chk({tag, "_pulse"}, {30'd0, mem_ready, bus_err}, 32'd0);
        chk({tag, "_aw_hs"}, aw_n - aw0, 32'(wr));
        chk({tag, "_w_hs"}, w_n - w0, 32'(wr));
        chk({tag, "_ar_hs"}, ar_n - ar0, 32'(!wr));
        chk({tag, "_protocol"}, proto_n - p0, 32'd0);
        if (wr) begin
            chk({tag, "_awaddr"}, cap_awaddr, a);
            chk({tag, "_wdata"}, cap_wdata, d);
            chk({tag, "_wstrb"}, 32'(cap_wstrb), 32'(s));
            chk({tag, "_awprot"}, 32'(cap_awprot), 32'd0);
        end else begin
            chk({tag, "_araddr"}, cap_araddr, a);
            chk({tag, "_arprot"}, 32'(cap_arprot), 32'd0);
        end
    endtask

    initial begin
        aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0; ar_never = 0;
        bresp_v = RESP_OKAY; rresp_v = RESP_OKAY; rdata_v = 32'h0;
        mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        exp_rdata = 32'h0;
        reset = 1;
        repeat (3) @(negedge clk);
        chk_quiet("reset_ctrl");
        chk("reset_rdata", mem_rdata, 32'h0);
        chk("reset_awaddr", m_awaddr, 32'h0);
        chk("reset_wdata", m_wdata, 32'h0);
        reset = 0;
        @(negedge clk);

        run(32'h0200_0004, 32'h0000_0068, 4'hF, "t1_write");
        r_d = 3; rdata_v = 32'h0000_0041;
        run(32'h0200_0008, 32'h0, 4'h0, "t2_read");
        r_d = 0;
        aw_d = 2; w_d = 0;
        run(32'h0200_0010, 32'hA5A5_0001, 4'h3, "t3_w_first");
        aw_d = 0; w_d = 2; bresp_v = RESP_SLVERR;
        run(32'h0200_0014, 32'h5A5A_0002, 4'hC, "t3_aw_first");
        w_d = 0; bresp_v = RESP_OKAY;
        rresp_v = RESP_DECERR; rdata_v = 32'h1234_5678;
        run(32'h0300_0000, 32'h0, 4'h0, "t4_decerr");
        rresp_v = RESP_OKAY; rdata_v = 32'h0000_0099;
        run(32'h0200_000C, 32'h0, 4'h0, "t4_okay");

        b_d = 6;
        mem_valid = 1; mem_addr = 32'h0200_0020; mem_wdata = 32'h77; mem_wstrb = 4'hF;
        @(negedge clk);
        mem_valid = 0;
        for (int i = 0; i < 20 && !m_bready; i++) @(negedge clk);
        chk("t5_in_wresp", 32'(m_bready), 32'd1);
        reset = 1;
        @(negedge clk);
        chk_quiet("t5_after_reset");
        chk("t5_rdata_cleared", mem_rdata, 32'h0);
        exp_rdata = 32'h0;
        reset = 0; b_d = 0;
        @(negedge clk);
        chk_quiet("t5_idle");
        rdata_v = 32'hCAFE_0005;
        run(32'h0200_0024, 32'h0, 4'h0, "t5_read");

        ar_never = 1;
        mem_valid = 1; mem_addr = 32'h0400_0000; mem_wstrb = 4'h0;
        begin
            int st, seen, lat;
            st = cyc; seen = 0; lat = 0;
`ifdef AXI_M_TIMEOUT_EN
            for (int i = 0; i < 60 && seen == 0; i++) begin
                @(negedge clk);
                if (mem_ready) begin seen = 1; lat = cyc - st + 1; end
            end
            chk("t6_timeout_ready", seen, 1);
            chk("t6_timeout_latency", lat, 18);
            chk("t6_timeout_rdata", mem_rdata, TIMEOUT_RDATA);
            chk("t6_timeout_bus_err", 32'(bus_err), 32'd1);
            mem_valid = 0;
            @(negedge clk);
            chk("t6_arvalid_low", 32'(m_arvalid), 32'd0);
            exp_rdata = TIMEOUT_RDATA;
`else
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (mem_ready) seen++;
            end
            chk("t6_no_ready", seen, 0);
            chk("t6_still_waiting", 32'(m_arvalid), 32'd1);
            mem_valid = 0;
            reset = 1;
            @(negedge clk);
            reset = 0;
            exp_rdata = 32'h0;
            @(negedge clk);
`endif
        end
        ar_never = 0;

        for (int k = 0; k < 24; k++) begin
            logic [3:0] s;
            aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_d = $urandom_range(0, 3);
            ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, 3);
            bresp_v = 2'($urandom); rresp_v = 2'($urandom); rdata_v = $urandom;
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            run($urandom, $urandom, s, $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
